mining_result_tx: RTL and testbench
===================================

Name: mining_result_tx

Overview:
- Downstream of the mining core. Captures each winning result (32-bit nonce plus 256-bit hash) on a single-cycle valid pulse.
- Serializes the result into a fixed byte frame and presents one byte at a time to the UART transmitter over a valid/ready handshake.
- Replaces the ad-hoc hash shift register. Adds framing, nonce reporting, back-pressure handling and a count of results dropped while busy.

Parameters:
- SYNC_BYTE, 8'hA5, first byte of every frame.
- HASH_BYTES, 32, number of hash bytes sent (256-bit hash).
- DROP_W, 8, width of the dropped-result counter.

Ports:
- clk_i  input  1  system clock; all logic rising-edge.
- rst_i  input  1  asynchronous, active-high reset.
- res_valid_i  input  1  single-cycle pulse: nonce_i/hash_i hold a valid result.
- nonce_i  input  32  winning nonce.
- hash_i  input  256  winning hash; byte 0 = hash_i[7:0].
- tx_ready_i  input  1  UART transmitter can accept a byte this cycle.
- tx_valid_o  output  1  tx_data_o holds a byte to send.
- tx_data_o  output  8  current frame byte.
- busy_o  output  1  frame in progress; new results are not accepted.
- drop_cnt_o  output  DROP_W  saturating count of results dropped while busy.

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE.
  - tx_valid_o=0, tx_data_o=0, busy_o=0, drop_cnt_o=0.
  - Capture registers cleared.
  - Reset mid-frame aborts the frame immediately; no partial resume.
- States:
  - IDLE: res_valid_i=1 latches nonce_i and hash_i into internal registers, then -> SYNC.
  - SYNC: sends SYNC_BYTE, then -> NONCE.
  - NONCE: sends 4 bytes, nonce[7:0] first, then -> HASH.
  - HASH: sends HASH_BYTES bytes, hash[7:0] first, then hash[15:8], and so on; then -> CHK if enabled, else IDLE.
  - CHK: optional; see Optional Feature.
- Latency:
  - tx_valid_o rises on the cycle after the res_valid_i capture cycle.
  - The first byte is SYNC_BYTE.
- Handshake:
  - A byte transfers on any cycle where tx_valid_o=1 and tx_ready_i=1.
  - The next byte, or IDLE, is presented on the following cycle.
  - tx_valid_o stays high between bytes within a frame; it never drops mid-frame.
  - tx_data_o is held stable while tx_valid_o=1 and tx_ready_i=0. Stall length is unbounded.
  - tx_ready_i is ignored when tx_valid_o=0.
- Byte index:
  - Internal counter, 0..HASH_BYTES-1, reused for NONCE and HASH.
  - Reset to 0 on each state entry.
  - Advances only on a transfer.
- busy_o:
  - High from the cycle after capture through the cycle on which the last byte transfers.
  - Low in IDLE.
- Drop rule:
  - res_valid_i while busy_o=1 is ignored for data; the capture registers are untouched.
  - drop_cnt_o increments by 1 on such a pulse and saturates at all-ones.
  - This includes a pulse on the same cycle the last byte transfers.
  - A pulse in IDLE is always accepted.
- Back-to-back results: minimum spacing is one IDLE cycle between frames.
- Frame length: 37 bytes without the optional feature.

Optional Feature:
- Macro: MINING_RESULT_CHKSUM_EN.
- Defined:
  - After the last hash byte, the block enters CHK and sends one byte: XOR of all 36 nonce and hash bytes (SYNC_BYTE excluded).
  - The XOR accumulator is cleared on capture and updated on each transfer.
  - Frame length is 38 bytes.
- Undefined:
  - CHK state and accumulator are not built.
  - HASH goes directly to IDLE; frame length is 37 bytes.

Test Plan:
- Basic frame:
  - Stimulus: after reset, res_valid_i pulse with nonce_i=32'h12345678, hash_i=256'h01..20 (byte k = k+1), tx_ready_i=1 constant.
  - Response: tx_valid_o rises 1 cycle later.
  - Bytes: A5, 78, 56, 34, 12, 01, 02 … 20 (37 bytes, one per cycle).
  - busy_o low on the cycle after the last byte.
- Back-pressure:
  - Stimulus: same result; tx_ready_i toggles 1,0,0,1,... pseudo-randomly.
  - Response: identical 37-byte sequence; tx_data_o constant during every ready=0 cycle; tx_valid_o never deasserts mid-frame.
- Drop while busy:
  - Stimulus: second res_valid_i with nonce_i=32'hDEADBEEF at byte 10 of the frame.
  - Response: frame unchanged; drop_cnt_o=1.
  - Third pulse one cycle after the frame ends: accepted, new frame starts with A5, EF, BE, AD, DE.
- Saturation:
  - Stimulus: 300 pulses while busy (tx_ready_i=0).
  - Response: drop_cnt_o=8'hFF, holds.
- Reset mid-frame:
  - Stimulus: assert rst_i at byte 20, asynchronously between edges.
  - Response: tx_valid_o, busy_o and drop_cnt_o go 0 immediately.
  - A new result after release produces a complete frame from A5.
- Checksum (MINING_RESULT_CHKSUM_EN defined):
  - Stimulus: nonce_i=0, hash_i with byte 0=8'h0F and all other bytes 0.
  - Response: 38th byte=8'h0F.
  - With nonce_i=32'hFF00FF00 and hash_i=0: 38th byte=8'h00.

Source files
------------

// File: rtl/mining_result_tx.sv
// Mining result serializer: captures nonce+hash and streams SYNC, nonce, hash bytes over valid/ready.
// Optional trailing XOR checksum byte when MINING_RESULT_CHKSUM_EN is defined.
module mining_result_tx #(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         HASH_BYTES = 32,
    parameter int         DROP_W     = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      res_valid_i,
    input  logic [31:0]               nonce_i,
    input  logic [8*HASH_BYTES-1:0]   hash_i,
    input  logic                      tx_ready_i,
    output logic                      tx_valid_o,
    output logic [7:0]                tx_data_o,
    output logic                      busy_o,
    output logic [DROP_W-1:0]         drop_cnt_o
);

    localparam int IW = (HASH_BYTES > 1) ? $clog2(HASH_BYTES) : 1;
    localparam logic [IW-1:0] LAST_HASH  = IW'(HASH_BYTES - 1);
    localparam logic [IW-1:0] LAST_NONCE = IW'(3);

`ifdef MINING_RESULT_CHKSUM_EN
    typedef enum logic [2:0] {IDLE, SYNC, NONCE, HASH, CHK} state_t;
`else
    typedef enum logic [2:0] {IDLE, SYNC, NONCE, HASH} state_t;
`endif

    state_t                  state_r, state_n;
    logic [IW-1:0]           idx_r, idx_n;
    logic [31:0]             nonce_r;
    logic [8*HASH_BYTES-1:0] hash_r;
    logic                    tx_valid_r, valid_n;
    logic [7:0]              tx_data_r, data_n;
    logic                    busy_r;
    logic [DROP_W-1:0]       drop_cnt_r;
    logic                    capture_s;
    logic                    xfer_s;
`ifdef MINING_RESULT_CHKSUM_EN
    logic [7:0]              chk_r;
`endif

    function automatic logic [7:0] nonce_byte(input logic [31:0] n, input logic [1:0] i);
        return n[{i, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] hash_byte(input logic [8*HASH_BYTES-1:0] h, input logic [IW-1:0] i);
        return h[{i, 3'b000} +: 8];
    endfunction

    assign xfer_s     = tx_valid_r & tx_ready_i;
    assign tx_valid_o = tx_valid_r;
    assign tx_data_o  = tx_data_r;
    assign busy_o     = busy_r;
    assign drop_cnt_o = drop_cnt_r;

    // Next-state and next-byte selection; outputs are registered from these.
    always_comb begin
        state_n   = state_r;
        idx_n     = idx_r;
        valid_n   = tx_valid_r;
        data_n    = tx_data_r;
        capture_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (res_valid_i) begin
                    capture_s = 1'b1;
                    state_n   = SYNC;
                    idx_n     = '0;
                    valid_n   = 1'b1;
                    data_n    = SYNC_BYTE;
                end else begin
                    valid_n = 1'b0;
                    data_n  = 8'h00;
                end
            end
            SYNC: begin
                if (xfer_s) begin
                    state_n = NONCE;
                    idx_n   = '0;
                    data_n  = nonce_r[7:0];
                end else begin
                    state_n = SYNC;
                end
            end
            NONCE: begin
                if (xfer_s) begin
                    if (idx_r == LAST_NONCE) begin
                        state_n = HASH;
                        idx_n   = '0;
                        data_n  = hash_r[7:0];
                    end else begin
                        idx_n  = idx_r + IW'(1);
                        data_n = nonce_byte(nonce_r, idx_r[1:0] + 2'd1);
                    end
                end else begin
                    state_n = NONCE;
                end
            end
            HASH: begin
                if (xfer_s) begin
                    if (idx_r == LAST_HASH) begin
`ifdef MINING_RESULT_CHKSUM_EN
                        // Fold in the byte transferring now; the accumulator lags by one.
                        state_n = CHK;
                        idx_n   = '0;
                        data_n  = chk_r ^ tx_data_r;
`else
                        state_n = IDLE;
                        idx_n   = '0;
                        valid_n = 1'b0;
                        data_n  = 8'h00;
`endif
                    end else begin
                        idx_n  = idx_r + IW'(1);
                        data_n = hash_byte(hash_r, idx_r + IW'(1));
                    end
                end else begin
                    state_n = HASH;
                end
            end
`ifdef MINING_RESULT_CHKSUM_EN
            CHK: begin
                if (xfer_s) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    data_n  = 8'h00;
                end else begin
                    state_n = CHK;
                end
            end
`endif
            default: begin
                state_n = IDLE;
                idx_n   = '0;
                valid_n = 1'b0;
                data_n  = 8'h00;
            end
        endcase
    end

    // State, byte index and registered handshake outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= IDLE;
            idx_r      <= '0;
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            idx_r      <= idx_n;
            tx_valid_r <= valid_n;
            tx_data_r  <= data_n;
            busy_r     <= (state_n != IDLE);
        end
    end

    // Result capture; untouched while a frame is in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            nonce_r <= 32'h0;
            hash_r  <= '0;
        end else if (capture_s) begin
            nonce_r <= nonce_i;
            hash_r  <= hash_i;
        end
    end

    // Saturating count of results arriving while busy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_cnt_r <= '0;
        end else if (res_valid_i && busy_r && (drop_cnt_r != '1)) begin
            drop_cnt_r <= drop_cnt_r + DROP_W'(1);
        end
    end

`ifdef MINING_RESULT_CHKSUM_EN
    // XOR of every nonce and hash byte as it transfers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chk_r <= 8'h00;
        end else if (capture_s) begin
            chk_r <= 8'h00;
        end else if (xfer_s && (state_r == NONCE || state_r == HASH)) begin
            chk_r <= chk_r ^ tx_data_r;
        end
    end
`endif

endmodule

// File: tb/tb_mining_result_tx.sv
// Scoreboard bench for mining_result_tx: expected frame bytes queued at result injection, popped per transfer.
module tb_mining_result_tx;

    logic         clk;
    logic         rst;
    logic         res_valid;
    logic [31:0]  nonce;
    logic [255:0] hash;
    logic         tx_ready;
    logic         tx_valid_o;
    logic [7:0]   tx_data_o;
    logic         busy_o;
    logic [7:0]   drop_cnt_o;

    int           checks;
    int           failures;
    logic [7:0]   exp_q[$];
    logic         model_busy;
    logic [7:0]   exp_drop;
    logic         prev_valid;
    logic         prev_ready;
    logic [7:0]   prev_data;
    logic [255:0] h_inc;
    logic [255:0] h_alt;
    logic [255:0] h_chk;

    mining_result_tx dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .res_valid_i (res_valid),
        .nonce_i     (nonce),
        .hash_i      (hash),
        .tx_ready_i  (tx_ready),
        .tx_valid_o  (tx_valid_o),
        .tx_data_o   (tx_data_o),
        .busy_o      (busy_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [31:0] n, input logic [255:0] h);
        logic [7:0] x;
        x = 8'h00;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(n[8*i +: 8]);
            x = x ^ n[8*i +: 8];
        end
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(h[8*i +: 8]);
            x = x ^ h[8*i +: 8];
        end
`ifdef MINING_RESULT_CHKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    // One cycle: observe at negedge, compare, then drive inputs for the next posedge.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] n, input logic [255:0] h);
        logic [7:0] e;
        logic       set_busy;
        logic       clr_busy;
        set_busy = 1'b0;
        clr_busy = 1'b0;
        @(negedge clk);
        tx_ready  = rdy;
        res_valid = rv;
        nonce     = n;
        hash      = h;
        check("busy", busy_o, model_busy);
        check("tx_valid", tx_valid_o, model_busy);
        check("drop_cnt", drop_cnt_o, exp_drop);
        if (prev_valid && !prev_ready && tx_valid_o)
            check("hold_data", tx_data_o, prev_data);
        if (rv) begin
            if (model_busy) begin
                if (exp_drop != 8'hFF) exp_drop = exp_drop + 8'd1;
            end else begin
                push_frame(n, h);
                set_busy = 1'b1;
            end
        end
        if (tx_valid_o && rdy) begin
            check("byte_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("tx_byte", tx_data_o, e);
                if (exp_q.size() == 0) clr_busy = 1'b1;
            end
        end
        if (clr_busy) model_busy = 1'b0;
        if (set_busy) model_busy = 1'b1;
        prev_valid = tx_valid_o;
        prev_ready = rdy;
        prev_data  = tx_data_o;
    endtask

    task automatic drain(input logic random_ready);
        for (int i = 0; i < 3000 && model_busy; i++)
            step(random_ready ? ($urandom_range(0, 2) != 0) : 1'b1, 1'b0, 32'h0, 256'h0);
        check("drain_timeout", model_busy, 1'b0);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        model_busy = 1'b0;
        exp_drop   = 8'h00;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_data  = 8'h00;
        rst        = 1'b1;
        res_valid  = 1'b0;
        nonce      = 32'h0;
        hash       = 256'h0;
        tx_ready   = 1'b0;
        for (int k = 0; k < 32; k++) begin
            h_inc[8*k +: 8] = 8'(k + 1);
            h_alt[8*k +: 8] = 8'(8'hC0 ^ k);
        end
        h_chk = 256'h0;
        h_chk[7:0] = 8'h0F;

        repeat (2) @(negedge clk);
        check("rst_tx_valid", tx_valid_o, 1'b0);
        check("rst_tx_data", tx_data_o, 8'h00);
        check("rst_busy", busy_o, 1'b0);
        check("rst_drop", drop_cnt_o, 8'h00);
        rst = 1'b0;

        // Basic frame, ready held high.
        step(1'b1, 1'b1, 32'h12345678, h_inc);
        drain(1'b0);
        step(1'b1, 1'b0, 32'h0, 256'h0);

        // Random back-pressure.
        step(1'b0, 1'b1, 32'h12345678, h_inc);
        drain(1'b1);

        // Drop while busy at byte 10, then re-accept one cycle after frame end.
        step(1'b1, 1'b1, 32'h12345678, h_inc);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 256'h0);
        step(1'b1, 1'b1, 32'hDEADBEEF, h_alt);
        drain(1'b0);
        check("drop_after_busy_pulse", drop_cnt_o, 8'd1);
        step(1'b0, 1'b1, 32'hDEADBEEF, h_alt);

        // Saturation under stall.
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 32'h55AA55AA, h_inc);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 256'h0);
        check("drop_saturated", drop_cnt_o, 8'hFF);
        drain(1'b1);
        check("drop_hold", drop_cnt_o, 8'hFF);

        // Asynchronous reset at byte 20.
        step(1'b1, 1'b1, 32'h12345678, h_inc);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 32'h0, 256'h0);
        #2 rst = 1'b1;
        #1;
        check("midrst_tx_valid", tx_valid_o, 1'b0);
        check("midrst_busy", busy_o, 1'b0);
        check("midrst_drop", drop_cnt_o, 8'h00);
        exp_q.delete();
        model_busy = 1'b0;
        exp_drop   = 8'h00;
        prev_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b1, 32'h12345678, h_inc);
        drain(1'b1);

        // Checksum patterns (plain 37-byte frames when the checksum is not built).
        step(1'b1, 1'b1, 32'h0, h_chk);
        drain(1'b0);
        step(1'b1, 1'b1, 32'hFF00FF00, 256'h0);
        drain(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
